// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared VGA 640x480@60 timing constants. The sync generator uses them,
//   and so does the pixel renderer.
//   Contents: default porch/sync/visible sizes, derived totals, counter width,
//   and prescaler terminal value.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // The 100 MHz system clock is divided by 4 to give the 25 MHz pixel rate.
    localparam logic [1:0] PRESCALE_LAST = 2'd3;

endpackage

// File: rtl/vga_sync_gen_pixel_tick.sv
// pixel_tick_gen
//   Free-running divide-by-4 prescaler that produces the pixel enable.
//   Ports:
//     clock_100Mhz : system clock, rising edge
//     reset        : asynchronous, active-low
//     pixel_tick   : high for one clock in every four, exactly while the
//                    prescaler sits at its terminal value
module pixel_tick_gen
    import vga_timing_pkg::*;
(
    input  logic clock_100Mhz,
    input  logic reset,
    output logic pixel_tick
);

    logic [1:0] prescaler;

    // The strobe is registered. It is loaded one count early, so it stays
    // high for exactly the cycle in which prescaler equals PRESCALE_LAST.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            prescaler  <= 2'd0;
            pixel_tick <= 1'b0;
        end else begin
            prescaler  <= prescaler + 2'd1;
            pixel_tick <= (prescaler == (PRESCALE_LAST - 2'd1));
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA raster timing generator: horizontal and vertical pixel counters,
//   active-low syncs, a visible-area flag and a start-of-frame strobe.
//   Ports:
//     clock_100Mhz : system clock, rising edge
//     reset        : asynchronous, active-low
//     pixel_tick   : 25 MHz pixel enable (one clock in four)
//     hsync        : horizontal sync, active-low
//     vsync        : vertical sync, active-low
//     video_on     : current pixel lies inside the visible area
//     pixel_x      : current column, 0 .. H_TOTAL-1
//     pixel_y      : current line, 0 .. V_TOTAL-1
//     frame_start  : one-clock pulse in the cycle after the wrap to (0,0)
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HSYNC_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HSYNC_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);

    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] VSYNC_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic             x_wrap;
    logic             y_wrap;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;

    pixel_tick_gen u_pixel_tick_gen (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .pixel_tick   (pixel_tick)
    );

    // Wrap is detected before increment, so the counters never hold a value
    // outside 0 .. TOTAL-1.
    always_comb begin
        x_wrap = pixel_tick && (pixel_x == H_LAST);
        y_wrap = x_wrap && (pixel_y == V_LAST);
        x_next = pixel_x;
        y_next = pixel_y;
        if (pixel_tick) begin
            x_next = x_wrap ? '0 : pixel_x + 1'b1;
        end
        if (x_wrap) begin
            y_next = y_wrap ? '0 : pixel_y + 1'b1;
        end
    end

    // The sync, visible and frame flags are decoded from the next counter
    // values. That keeps them aligned with pixel_x/pixel_y in the same cycle,
    // even though they are registered.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            hsync       <= !((x_next >= HSYNC_FIRST) && (x_next <= HSYNC_LAST));
            vsync       <= !((y_next >= VSYNC_FIRST) && (y_next <= VSYNC_LAST));
            video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_start <= y_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    logic       clock_100Mhz;
    logic       reset;

    // default-timing instance
    logic       d_tick, d_hs, d_vs, d_von, d_fs;
    logic [9:0] d_x, d_y;
    // shrunken-timing instance: H 8/2/3/2 (15), V 6/1/2/2 (11)
    logic       s_tick, s_hs, s_vs, s_von, s_fs;
    logic [9:0] s_x, s_y;

    vga_sync_gen dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .pixel_tick   (d_tick),
        .hsync        (d_hs),
        .vsync        (d_vs),
        .video_on     (d_von),
        .pixel_x      (d_x),
        .pixel_y      (d_y),
        .frame_start  (d_fs)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2)
    ) dut_s (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .pixel_tick   (s_tick),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .video_on     (s_von),
        .pixel_x      (s_x),
        .pixel_y      (s_y),
        .frame_start  (s_fs)
    );

    initial clock_100Mhz = 1'b0;
    always #5 clock_100Mhz = ~clock_100Mhz;

    typedef struct {
        int         n;      // rising edges since reset release
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    int nvec;
    int nmis;
    int n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s n=%0d got %0d expected %0d", name, n, act, exp);
        end
    endtask

    // Independent reference for the shrunken instance. After n edges,
    // n/4 ticks have been consumed.
    task automatic check_small();
        int t, ex, ey;
        t  = n / 4;
        ex = t % 15;
        ey = (t / 15) % 11;
        chk("s_tick", {31'd0, s_tick}, (n % 4 == 3) ? 1 : 0);
        chk("s_x", {22'd0, s_x}, ex);
        chk("s_y", {22'd0, s_y}, ey);
        chk("s_hsync", {31'd0, s_hs}, (ex >= 10 && ex <= 12) ? 0 : 1);
        chk("s_vsync", {31'd0, s_vs}, (ey >= 7 && ey <= 8) ? 0 : 1);
        chk("s_video_on", {31'd0, s_von}, (n > 0 && ex < 8 && ey < 6) ? 1 : 0);
        chk("s_frame_start", {31'd0, s_fs}, (n > 0 && n % 4 == 0 && t % 165 == 0) ? 1 : 0);
    endtask

    task automatic check_reset_values();
        chk("rst_d_tick", {31'd0, d_tick}, 0);
        chk("rst_d_x", {22'd0, d_x}, 0);
        chk("rst_d_y", {22'd0, d_y}, 0);
        chk("rst_d_hsync", {31'd0, d_hs}, 1);
        chk("rst_d_vsync", {31'd0, d_vs}, 1);
        chk("rst_d_video_on", {31'd0, d_von}, 0);
        chk("rst_d_frame_start", {31'd0, d_fs}, 0);
        chk("rst_s_tick", {31'd0, s_tick}, 0);
        chk("rst_s_x", {22'd0, s_x}, 0);
        chk("rst_s_y", {22'd0, s_y}, 0);
        chk("rst_s_hsync", {31'd0, s_hs}, 1);
        chk("rst_s_vsync", {31'd0, s_vs}, 1);
        chk("rst_s_video_on", {31'd0, s_von}, 0);
        chk("rst_s_frame_start", {31'd0, s_fs}, 0);
    endtask

    initial begin
        int idx, fs_cnt, vis_cnt, hs_low, d_hs_low, d_tick_cnt;
        bit found;

        nvec = 0;
        nmis = 0;
        n    = 0;

        //        n      x    y  hs vs von tick
        tbl[0]  = '{0,     0,   0, 1, 1, 0, 0};
        tbl[1]  = '{1,     0,   0, 1, 1, 1, 0};
        tbl[2]  = '{3,     0,   0, 1, 1, 1, 1};
        tbl[3]  = '{4,     1,   0, 1, 1, 1, 0};
        tbl[4]  = '{7,     1,   0, 1, 1, 1, 1};
        tbl[5]  = '{8,     2,   0, 1, 1, 1, 0};
        tbl[6]  = '{2556,  639, 0, 1, 1, 1, 0};
        tbl[7]  = '{2560,  640, 0, 1, 1, 0, 0};
        tbl[8]  = '{2620,  655, 0, 1, 1, 0, 0};
        tbl[9]  = '{2624,  656, 0, 0, 1, 0, 0};
        tbl[10] = '{3004,  751, 0, 0, 1, 0, 0};
        tbl[11] = '{3008,  752, 0, 1, 1, 0, 0};
        tbl[12] = '{3196,  799, 0, 1, 1, 0, 0};
        tbl[13] = '{3199,  799, 0, 1, 1, 0, 1};
        tbl[14] = '{3200,  0,   1, 1, 1, 1, 0};
        tbl[15] = '{3203,  0,   1, 1, 1, 1, 1};

        reset = 1'b0;
        repeat (3) @(posedge clock_100Mhz);
        #1;
        check_reset_values();

        @(negedge clock_100Mhz);
        reset = 1'b1;
        #1;
        n = 0;
        idx = 0;
        fs_cnt = 0; vis_cnt = 0; hs_low = 0; d_hs_low = 0; d_tick_cnt = 0;

        // First run: one default line plus several small frames, every cycle.
        while (n <= 3400) begin
            check_small();
            if (idx < NVEC && tbl[idx].n == n) begin
                chk("d_x", {22'd0, d_x}, {22'd0, tbl[idx].x});
                chk("d_y", {22'd0, d_y}, {22'd0, tbl[idx].y});
                chk("d_hsync", {31'd0, d_hs}, {31'd0, tbl[idx].hs});
                chk("d_vsync", {31'd0, d_vs}, {31'd0, tbl[idx].vs});
                chk("d_video_on", {31'd0, d_von}, {31'd0, tbl[idx].von});
                chk("d_tick", {31'd0, d_tick}, {31'd0, tbl[idx].tick});
                chk("d_frame_start", {31'd0, d_fs}, 0);
                idx++;
            end
            if (s_fs) fs_cnt++;
            if (n >= 1 && n <= 660 && s_tick && s_von) vis_cnt++;
            if (n >= 1 && n <= 660 && s_tick && !s_hs) hs_low++;
            if (n >= 1 && n <= 3200 && d_tick && !d_hs) d_hs_low++;
            if (n >= 1 && n <= 400 && d_tick) d_tick_cnt++;
            @(posedge clock_100Mhz);
            #1;
            n++;
        end
        chk("tbl_all_hit", idx, NVEC);
        chk("s_frame_start_count", fs_cnt, 5);
        chk("s_visible_ticks_frame", vis_cnt, 48);
        chk("s_hsync_low_ticks_frame", hs_low, 33);
        chk("d_hsync_low_ticks_line", d_hs_low, 96);
        chk("d_tick_one_in_four", d_tick_cnt, 100);

        // Mid-frame reset while the small instance is inside its hsync pulse.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (s_x == 10'd12 && s_y == 10'd4) found = 1'b1;
            else begin
                @(posedge clock_100Mhz);
                #1;
            end
        end
        chk("midframe_target_reached", {31'd0, found}, 1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clock_100Mhz);
        #1;
        check_reset_values();

        @(negedge clock_100Mhz);
        reset = 1'b1;
        #1;
        n = 0;
        while (n <= 700) begin
            check_small();
            chk("d_x_restart", {22'd0, d_x}, (n / 4) % 800);
            chk("d_tick_restart", {31'd0, d_tick}, (n % 4 == 3) ? 1 : 0);
            @(posedge clock_100Mhz);
            #1;
            n++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
